// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the uart_tx arbiter: FSM encoding, requester
// count and the ACCEPT-state wait limit.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACCEPT,
    ARB_DRAIN
  } arb_state_t;

  localparam int NUM_REQ     = 2;
  localparam int ACCEPT_WAIT = 2;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester, forced-owner and uart_tx handshake bundle of the arbiter.
// slave is the arbiter's view; master is the surrounding top level's view.
interface uart_tx_arbiter_if;
  import uart_arb_pkg::*;

  logic [NUM_REQ-1:0]   i_req_stb;
  logic [8*NUM_REQ-1:0] i_req_data;
  logic [NUM_REQ-1:0]   o_req_busy;
  logic                 i_force_en;
  logic                 i_force_sel;
  logic [7:0]           o_tx_data;
  logic                 o_tx_stb;
  logic                 i_tx_busy;
  logic [NUM_REQ-1:0]   o_owner;

  modport slave (
    input  i_req_stb, i_req_data, i_force_en, i_force_sel, i_tx_busy,
    output o_req_busy, o_tx_data, o_tx_stb, o_owner
  );

  modport master (
    output i_req_stb, i_req_data, i_force_en, i_force_sel, i_tx_busy,
    input  o_req_busy, o_tx_data, o_tx_stb, o_owner
  );

endinterface

// File: rtl/uart_arb_hold.sv
// One-byte holding register for a single requester. A strobe is only taken
// while empty; the arbiter empties it in the cycle its byte is launched.
module uart_arb_hold (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_stb,
  input  logic [7:0] i_data,
  input  logic       i_clear,
  output logic       o_busy,
  output logic [7:0] o_data
);

  // Clear only applies when full, so it can never race a capture.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_busy <= 1'b0;
      o_data <= '0;
    end else if (i_clear) begin
      o_busy <= 1'b0;
    end else if (i_stb && !o_busy) begin
      o_busy <= 1'b1;
      o_data <= i_data;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between the ihex controller (req 0)
// and the wbuart buffer (req 1). Define UART_ARB_PKT_LOCK_EN for packet locking.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int         IDLE_TIMEOUT = 1024,
  parameter logic [7:0] EOL_CHAR     = 8'h0A
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  uart_tx_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(IDLE_TIMEOUT + 1);
  localparam int ACC_W = (ACCEPT_WAIT > 1) ? $clog2(ACCEPT_WAIT) : 1;

  arb_state_t         state_q, state_d;
  logic [ACC_W-1:0]   acc_cnt_q, acc_cnt_d;
  logic               tx_stb_q, tx_stb_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic [NUM_REQ-1:0] owner_q, owner_d;
  logic               rr_q, rr_d;

  logic [NUM_REQ-1:0] full, clear, force_mask, lock_mask, elig;
  logic [7:0]         hold_data [NUM_REQ];
  logic               win, grant;

  for (genvar n = 0; n < NUM_REQ; n++) begin : g_hold
    uart_arb_hold u_hold (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_stb     (bus.i_req_stb[n]),
      .i_data    (bus.i_req_data[8*n +: 8]),
      .i_clear   (clear[n]),
      .o_busy    (full[n]),
      .o_data    (hold_data[n])
    );
  end

  assign clear          = {NUM_REQ{tx_stb_q}} & owner_q;
  assign bus.o_req_busy = full;
  assign bus.o_tx_stb   = tx_stb_q;
  assign bus.o_tx_data  = tx_data_q;
  assign bus.o_owner    = owner_q;

  // Force inputs only matter when grant is evaluated, which happens in IDLE.
  assign force_mask = bus.i_force_en ? (bus.i_force_sel ? 2'b10 : 2'b01) : 2'b11;
  assign elig       = full & force_mask & lock_mask;
  assign win        = (elig == 2'b11) ? ~rr_q : elig[1];
  assign grant      = (state_q == ARB_IDLE) && (elig != '0) && !bus.i_tx_busy;

`ifdef UART_ARB_PKT_LOCK_EN
  logic             lock_q, lock_owner_q, lock_eff, timeout;
  logic [CNT_W-1:0] idle_cnt_q;

  assign timeout   = (idle_cnt_q == CNT_W'(IDLE_TIMEOUT));
  assign lock_eff  = lock_q && !timeout &&
                     !(bus.i_force_en && (lock_owner_q != bus.i_force_sel));
  assign lock_mask = !lock_eff ? 2'b11 : (lock_owner_q ? 2'b10 : 2'b01);

  // The idle count tops out at IDLE_TIMEOUT, which drops the lock that cycle.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      lock_q       <= 1'b0;
      lock_owner_q <= 1'b0;
      idle_cnt_q   <= '0;
    end else if (grant) begin
      lock_q       <= (hold_data[win] != EOL_CHAR);
      lock_owner_q <= win;
      idle_cnt_q   <= '0;
    end else if (state_q == ARB_IDLE) begin
      if (!lock_eff) begin
        lock_q     <= 1'b0;
        idle_cnt_q <= '0;
      end else if (!full[lock_owner_q]) begin
        idle_cnt_q <= idle_cnt_q + 1'b1;
      end
    end
  end
`else
  logic [CNT_W+7:0] unused_lock_cfg;

  assign lock_mask       = '1;
  assign unused_lock_cfg = {CNT_W'(IDLE_TIMEOUT), EOL_CHAR};
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= ARB_IDLE;
      acc_cnt_q <= '0;
      tx_stb_q  <= 1'b0;
      tx_data_q <= '0;
      owner_q   <= '0;
      rr_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_cnt_q <= acc_cnt_d;
      tx_stb_q  <= tx_stb_d;
      tx_data_q <= tx_data_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
    end
  end

  // A serializer that never raises busy is treated as having finished the byte.
  always_comb begin
    state_d   = state_q;
    acc_cnt_d = acc_cnt_q;
    tx_stb_d  = 1'b0;
    tx_data_d = tx_data_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    case (state_q)
      ARB_IDLE: begin
        if (grant) begin
          tx_stb_d  = 1'b1;
          tx_data_d = hold_data[win];
          owner_d   = win ? 2'b10 : 2'b01;
          rr_d      = win;
          acc_cnt_d = '0;
          state_d   = ARB_ACCEPT;
        end
      end
      ARB_ACCEPT: begin
        if (bus.i_tx_busy || (acc_cnt_q == ACC_W'(ACCEPT_WAIT - 1))) begin
          state_d = ARB_DRAIN;
        end else begin
          acc_cnt_d = acc_cnt_q + 1'b1;
        end
      end
      ARB_DRAIN: begin
        if (!bus.i_tx_busy) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

endmodule
